// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared constants and state encoding for the FP adder control.
//  Revision    : 1.0
// ============================================================================
package fp_add_pkg;

    localparam int EXP_W       = 8;
    localparam int SUM_W       = 26;
    localparam int MAX_ALIGN   = 26;
    localparam int ALIGN_CNT_W = $clog2(MAX_ALIGN + 1);
    localparam int NORM_CNT_W  = $clog2(MAX_ALIGN + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_COMPARE = 4'd2,
        S_ALIGN   = 4'd3,
        S_ADD     = 4'd4,
        S_NORM    = 4'd5,
        S_ROUND   = 4'd6,
        S_POST    = 4'd7,
        S_DONE    = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_add_shift_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_shift_cnt
//  Description : Loadable down-counter with zero/one detect (alignment count).
//  Revision    : 1.0
// ============================================================================
module fp_add_shift_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_zero,
    output logic             o_is_one
);

    logic [CNT_W-1:0] r_count;

    // Saturates at zero so a stray decrement never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_is_zero = (r_count == '0);
    assign o_is_one  = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/fp_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_ctrl
//  Description : Sequencing FSM for the single-precision FP adder datapath.
//  Revision    : 1.0
// ============================================================================
module fp_add_ctrl #(
    parameter int EXP_W     = fp_add_pkg::EXP_W,
    parameter int SUM_W     = fp_add_pkg::SUM_W,
    parameter int MAX_ALIGN = fp_add_pkg::MAX_ALIGN
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_diff,
    input  logic             special,
    input  logic             sum_zero,
    input  logic             sum_ovf,
    input  logic             sum_msb,
    input  logic             exp_at_min,
    input  logic             exp_at_max,
    output logic             busy,
    output logic             done,
    output logic             exp_ovf,
    output logic             zero_result,
    output logic             bypass_sel,
    output logic             dp_clear,
    output logic             load_ops,
    output logic             swap_load,
    output logic             shift_align,
    output logic             load_sum,
    output logic             shift_left,
    output logic             shift_right,
    output logic             exp_dec,
    output logic             exp_inc,
    output logic             round_en
);

    import fp_add_pkg::*;

    localparam int c_align_w = $clog2(MAX_ALIGN + 1);
    localparam int c_norm_w  = $clog2(SUM_W);

    localparam logic [EXP_W-1:0]     c_max_align_e = EXP_W'(MAX_ALIGN);
    localparam logic [c_align_w-1:0] c_max_align_c = c_align_w'(MAX_ALIGN);
    localparam logic [c_norm_w-1:0]  c_norm_max    = c_norm_w'(SUM_W - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_norm_w-1:0]  r_norm_cnt;
    logic                 r_exp_ovf;
    logic                 r_zero_result;
    logic                 r_bypass_sel;

    logic                 w_set_ovf;
    logic                 w_set_zero;
    logic                 w_set_bypass;
    logic                 w_align_load;
    logic                 w_align_dec;
    logic                 w_align_zero;
    logic                 w_align_one;
    logic                 w_norm_inc;
    logic [c_align_w-1:0] w_align_val;

    // Differences beyond the cap shift the smaller mantissa out completely.
    assign w_align_val = (exp_diff > c_max_align_e) ? c_max_align_c
                                                    : exp_diff[c_align_w-1:0];

    fp_add_shift_cnt #(
        .CNT_W (c_align_w)
    ) u_align_cnt (
        .clk        (clk),
        .rst        (clear),
        .i_load     (w_align_load),
        .i_load_val (w_align_val),
        .i_dec      (w_align_dec),
        .o_is_zero  (w_align_zero),
        .o_is_one   (w_align_one)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_norm_cnt    <= '0;
            r_exp_ovf     <= 1'b0;
            r_zero_result <= 1'b0;
            r_bypass_sel  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_ADD) begin
                r_norm_cnt <= '0;
            end else if (w_norm_inc) begin
                r_norm_cnt <= r_norm_cnt + 1'b1;
            end

            // Result flags live until the completion cycle retires.
            if (r_state == S_DONE) begin
                r_exp_ovf     <= 1'b0;
                r_zero_result <= 1'b0;
                r_bypass_sel  <= 1'b0;
            end else begin
                r_exp_ovf     <= r_exp_ovf     | w_set_ovf;
                r_zero_result <= r_zero_result | w_set_zero;
                r_bypass_sel  <= r_bypass_sel  | w_set_bypass;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_set_ovf    = 1'b0;
        w_set_zero   = 1'b0;
        w_set_bypass = 1'b0;
        w_align_load = 1'b0;
        w_align_dec  = 1'b0;
        w_norm_inc   = 1'b0;
        done         = 1'b0;
        dp_clear     = 1'b0;
        load_ops     = 1'b0;
        swap_load    = 1'b0;
        shift_align  = 1'b0;
        load_sum     = 1'b0;
        shift_left   = 1'b0;
        shift_right  = 1'b0;
        exp_dec      = 1'b0;
        exp_inc      = 1'b0;
        round_en     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_ops    = 1'b1;
                dp_clear    = 1'b1;
                w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (special) begin
                    w_set_bypass = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    swap_load    = 1'b1;
                    w_align_load = 1'b1;
                    w_state_nxt  = (w_align_val == '0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                shift_align = 1'b1;
                w_align_dec = 1'b1;
                if (w_align_one || w_align_zero) begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                load_sum    = 1'b1;
                w_state_nxt = S_NORM;
            end
            S_NORM: begin
                if (sum_ovf) begin
                    if (exp_at_max) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        shift_right = 1'b1;
                        exp_inc     = 1'b1;
                        w_state_nxt = S_ROUND;
                    end
                end else if (sum_zero) begin
                    w_set_zero  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (sum_msb || exp_at_min || (r_norm_cnt == c_norm_max)) begin
                    w_state_nxt = S_ROUND;
                end else begin
                    shift_left = 1'b1;
                    exp_dec    = 1'b1;
                    w_norm_inc = 1'b1;
                end
            end
            S_ROUND: begin
                round_en    = 1'b1;
                w_state_nxt = S_POST;
            end
            S_POST: begin
                if (sum_ovf && exp_at_max) begin
                    w_set_ovf = 1'b1;
                end else if (sum_ovf) begin
                    shift_right = 1'b1;
                    exp_inc     = 1'b1;
                end
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign exp_ovf     = r_exp_ovf     | w_set_ovf;
    assign zero_result = r_zero_result | w_set_zero;
    assign bypass_sel  = r_bypass_sel  | w_set_bypass;

endmodule
`default_nettype wire
